// File: rtl/lap_timer_pkg.sv
// rtl/lap_timer_pkg.sv - shared widths, field limits, FSM encoding and time packing for the lap timer
package lap_timer_pkg;
    localparam int TIME_W  = 21;
    localparam int FIELD_W = 7;
    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;

    typedef logic [TIME_W-1:0]  lap_time_t;
    typedef logic [FIELD_W-1:0] time_field_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic lap_time_t pack_time(input time_field_t i_min,
                                            input time_field_t i_sec,
                                            input time_field_t i_cs);
        return {i_min, i_sec, i_cs};
    endfunction
endpackage

// File: rtl/lap_time_base.sv
// rtl/lap_time_base.sv - centisecond prescaler and cascaded cs/sec/min counters
// Zeroing has priority over a tick in the same cycle; the count holds at MAX_MIN:59:99.
module lap_time_base
    import lap_timer_pkg::*;
#(
    parameter int CLK_DIV = 500000,
    parameter int MAX_MIN = 99
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    input  logic              i_zero,
    output logic              o_tick,
    output logic [TIME_W-1:0] o_time
);
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam time_field_t CS_LAST  = FIELD_W'(CS_MAX);
    localparam time_field_t SEC_LAST = FIELD_W'(SEC_MAX);
    localparam time_field_t MIN_LAST = FIELD_W'(MAX_MIN);

    logic [PRE_W-1:0] r_pre;
    time_field_t      r_min;
    time_field_t      r_sec;
    time_field_t      r_cs;
    logic             w_at_max;

    assign o_tick   = i_run && (r_pre == PRE_LAST);
    assign w_at_max = (r_min == MIN_LAST) && (r_sec == SEC_LAST) && (r_cs == CS_LAST);
    assign o_time   = pack_time(r_min, r_sec, r_cs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_min <= '0;
            r_sec <= '0;
            r_cs  <= '0;
        end else if (i_zero) begin
            r_pre <= '0;
            r_min <= '0;
            r_sec <= '0;
            r_cs  <= '0;
        end else if (i_run) begin
            r_pre <= o_tick ? '0 : r_pre + 1'b1;
            if (o_tick && !w_at_max) begin
                if (r_cs != CS_LAST) begin
                    r_cs <= r_cs + 1'b1;
                end else begin
                    r_cs <= '0;
                    if (r_sec != SEC_LAST) begin
                        r_sec <= r_sec + 1'b1;
                    end else begin
                        r_sec <= '0;
                        r_min <= r_min + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/lap_timer_core.sv
// rtl/lap_timer_core.sv - multi-lap laser timer: break detect, run FSM, best/last lap and ring history
module lap_timer_core
    import lap_timer_pkg::*;
#(
    parameter int CLK_DIV     = 500000,
    parameter int LOCKOUT_SEC = 5,
    parameter int MAX_MIN     = 99,
    parameter int LAP_DEPTH   = 8,
    parameter int CNT_W       = 8
) (
    input  logic                         master_clk,
    input  logic                         rs,
    input  logic                         laser_detector,
    input  logic                         clear,
    output logic                         running,
    output logic                         lockout,
    output logic [TIME_W-1:0]            cur_time,
    output logic                         lap_strobe,
    output logic [TIME_W-1:0]            last_lap,
    output logic [TIME_W-1:0]            best_lap,
    output logic                         best_valid,
    output logic [CNT_W-1:0]             lap_count,
    output logic                         overflow,
    input  logic                         rd_en,
    input  logic [$clog2(LAP_DEPTH)-1:0] rd_idx,
    output logic [TIME_W-1:0]            rd_data,
    output logic                         rd_hit
);
    localparam int IDX_W = $clog2(LAP_DEPTH);
    localparam int CMP_W = (CNT_W > IDX_W) ? CNT_W : IDX_W;
    localparam lap_time_t LOCK_TIME = pack_time(FIELD_W'(LOCKOUT_SEC / 60),
                                                FIELD_W'(LOCKOUT_SEC % 60), FIELD_W'(0));
    localparam lap_time_t MAX_TIME  = pack_time(FIELD_W'(MAX_MIN), FIELD_W'(SEC_MAX),
                                                FIELD_W'(CS_MAX));

    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync_d;
    logic              r_brk;
    logic [0:0]        r_state;
    logic [TIME_W-1:0] r_last_lap;
    logic [TIME_W-1:0] r_best_lap;
    logic              r_best_valid;
    logic [CNT_W-1:0]  r_lap_count;
    logic              r_overflow;
    logic              r_lap_strobe;
    logic [IDX_W-1:0]  r_wr_ptr;
    logic [TIME_W-1:0] r_hist [LAP_DEPTH];
    logic [TIME_W-1:0] r_rd_data;
    logic              r_rd_hit;

    logic              w_tick;
    logic [TIME_W-1:0] w_cur_time;
    logic              w_running;
    logic              w_lockout;
    logic              w_start;
    logic              w_lap;
    logic              w_zero;
    logic              w_rd_hit;
    logic [IDX_W-1:0]  w_rd_addr;

    lap_time_base #(
        .CLK_DIV (CLK_DIV),
        .MAX_MIN (MAX_MIN)
    ) u_time_base (
        .clk    (master_clk),
        .rst    (rs),
        .i_run  (w_running),
        .i_zero (w_zero),
        .o_tick (w_tick),
        .o_time (w_cur_time)
    );

    // Idles high (beam intact); clear deliberately leaves this path untouched.
    always_ff @(posedge master_clk or posedge rs) begin
        if (rs) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
            r_brk    <= 1'b0;
        end else begin
            r_sync1  <= laser_detector;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            r_brk    <= r_sync_d & ~r_sync2;
        end
    end

    assign w_running = (r_state == ST_RUN);
    assign w_lockout = w_running && (w_cur_time < LOCK_TIME);
    assign w_start   = !clear && !w_running && r_brk;
    assign w_lap     = !clear && w_running && r_brk && !w_lockout;
    assign w_zero    = clear || w_start || w_lap;
    assign w_rd_addr = r_wr_ptr - IDX_W'(1) - rd_idx;
    // rd_idx never reaches LAP_DEPTH, so comparing against lap_count alone covers min(lap_count, LAP_DEPTH).
    assign w_rd_hit  = CMP_W'(rd_idx) < CMP_W'(r_lap_count);

    always_ff @(posedge master_clk or posedge rs) begin
        if (rs) begin
            r_state      <= ST_IDLE;
            r_last_lap   <= '0;
            r_best_lap   <= '0;
            r_best_valid <= 1'b0;
            r_lap_count  <= '0;
            r_overflow   <= 1'b0;
            r_lap_strobe <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_data    <= '0;
            r_rd_hit     <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) r_hist[i] <= '0;
        end else if (clear) begin
            r_state      <= ST_IDLE;
            r_last_lap   <= '0;
            r_best_lap   <= '0;
            r_best_valid <= 1'b0;
            r_lap_count  <= '0;
            r_overflow   <= 1'b0;
            r_lap_strobe <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_data    <= '0;
            r_rd_hit     <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) r_hist[i] <= '0;
        end else begin
            r_lap_strobe <= 1'b0;
            if (w_start) begin
                r_state      <= ST_RUN;
                r_lap_count  <= '0;
                r_best_valid <= 1'b0;
                r_overflow   <= 1'b0;
                r_wr_ptr     <= '0;
            end else if (w_lap) begin
                r_last_lap         <= w_cur_time;
                r_hist[r_wr_ptr]   <= w_cur_time;
                r_wr_ptr           <= r_wr_ptr + 1'b1;
                if (!r_best_valid || (w_cur_time < r_best_lap)) r_best_lap <= w_cur_time;
                r_best_valid       <= 1'b1;
                if (r_lap_count != {CNT_W{1'b1}}) r_lap_count <= r_lap_count + 1'b1;
                r_lap_strobe       <= 1'b1;
                r_overflow         <= 1'b0;
            end else if (w_tick && (w_cur_time == MAX_TIME)) begin
                r_overflow <= 1'b1;
            end
            // Reads see the pre-write history because the write above lands on the same edge.
            r_rd_hit  <= rd_en && w_rd_hit;
            r_rd_data <= (rd_en && w_rd_hit) ? r_hist[w_rd_addr] : '0;
        end
    end

    assign running    = w_running;
    assign lockout    = w_lockout;
    assign cur_time   = w_cur_time;
    assign lap_strobe = r_lap_strobe;
    assign last_lap   = r_last_lap;
    assign best_lap   = r_best_lap;
    assign best_valid = r_best_valid;
    assign lap_count  = r_lap_count;
    assign overflow   = r_overflow;
    assign rd_data    = r_rd_data;
    assign rd_hit     = r_rd_hit;
endmodule

// File: tb/tb_lap_timer_core.sv
// tb/tb_lap_timer_core.sv - randomized self-checking bench for lap_timer_core against a lap-list model
module tb_lap_timer_core;
    localparam int CLK_DIV     = 4;
    localparam int LOCKOUT_SEC = 1;
    localparam int MAX_MIN     = 2;
    localparam int LAP_DEPTH   = 4;
    localparam int CNT_W       = 8;
    localparam int MAX_CS      = (MAX_MIN * 60 + 59) * 100 + 99;
    localparam int LOCK_CS     = LOCKOUT_SEC * 100;

    logic        master_clk = 1'b0;
    logic        rs = 1'b1;
    logic        laser_detector = 1'b1;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_idx = 2'd0;
    logic        running;
    logic        lockout;
    logic [20:0] cur_time;
    logic        lap_strobe;
    logic [20:0] last_lap;
    logic [20:0] best_lap;
    logic        best_valid;
    logic [7:0]  lap_count;
    logic        overflow;
    logic [20:0] rd_data;
    logic        rd_hit;

    lap_timer_core #(
        .CLK_DIV     (CLK_DIV),
        .LOCKOUT_SEC (LOCKOUT_SEC),
        .MAX_MIN     (MAX_MIN),
        .LAP_DEPTH   (LAP_DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .master_clk     (master_clk),
        .rs             (rs),
        .laser_detector (laser_detector),
        .clear          (clear),
        .running        (running),
        .lockout        (lockout),
        .cur_time       (cur_time),
        .lap_strobe     (lap_strobe),
        .last_lap       (last_lap),
        .best_lap       (best_lap),
        .best_valid     (best_valid),
        .lap_count      (lap_count),
        .overflow       (overflow),
        .rd_en          (rd_en),
        .rd_idx         (rd_idx),
        .rd_data        (rd_data),
        .rd_hit         (rd_hit)
    );

    always #5 master_clk = ~master_clk;

    int cyc = 0;
    always @(posedge master_clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Model: elapsed clock edges since the last zeroing point, plus the list of completed laps in centiseconds.
    bit m_run;
    bit m_bv;
    int m_count;
    int m_last;
    int m_best;
    int zero;
    int m_laps[$];

    function automatic logic [20:0] to_time(input int cs);
        int c;
        c = (cs > MAX_CS) ? MAX_CS : cs;
        return {7'(c / 6000), 7'((c / 100) % 60), 7'(c % 100)};
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_bv = 1'b0;
        m_count = 0;
        m_last = 0;
        m_best = 0;
        m_laps.delete();
        zero = cyc;
    endtask

    task automatic do_break(input bit with_clear, input bit with_read);
        int a;
        int cs;
        int n;
        int ecs;
        bit strobe;
        bit pre_hit;
        logic [20:0] pre_data;
        laser_detector = 1'b0;
        repeat (3) @(posedge master_clk);
        @(negedge master_clk);
        if (with_clear) clear = 1'b1;
        if (with_read) begin
            rd_en = 1'b1;
            rd_idx = 2'd0;
        end
        n = m_laps.size();
        pre_hit = (n > 0);
        pre_data = pre_hit ? to_time(m_laps[n-1]) : 21'd0;
        @(posedge master_clk);
        @(negedge master_clk);
        clear = 1'b0;
        rd_en = 1'b0;
        a = cyc;
        cs = (a - 1 - zero) / CLK_DIV;
        strobe = 1'b0;
        if (with_clear) begin
            model_reset();
        end else if (!m_run) begin
            m_run = 1'b1;
            zero = a;
            m_count = 0;
            m_bv = 1'b0;
            m_laps.delete();
        end else if (cs >= LOCK_CS) begin
            if (cs > MAX_CS) cs = MAX_CS;
            m_laps.push_back(cs);
            m_last = cs;
            if (!m_bv || cs < m_best) m_best = cs;
            m_bv = 1'b1;
            if (m_count < 255) m_count++;
            strobe = 1'b1;
            zero = a;
        end
        ecs = m_run ? (cyc - zero) / CLK_DIV : 0;
        vectors++;
        if ({running, lockout, lap_strobe, lap_count, best_valid, overflow} !==
            {m_run, m_run && (ecs < LOCK_CS), strobe, 8'(m_count), m_bv, m_run && (ecs > MAX_CS)}) begin
            miscompares++;
            $display("FAIL break_status @%0d: got run/lock/strobe/cnt/bv/ovf=%b want %b", a,
                     {running, lockout, lap_strobe, lap_count, best_valid, overflow},
                     {m_run, m_run && (ecs < LOCK_CS), strobe, 8'(m_count), m_bv, m_run && (ecs > MAX_CS)});
        end
        vectors++;
        if (cur_time !== (m_run ? to_time(ecs) : 21'd0)) begin
            miscompares++;
            $display("FAIL break_cur_time @%0d: got %h want %h", a, cur_time,
                     m_run ? to_time(ecs) : 21'd0);
        end
        if (m_bv || !m_run) begin
            vectors++;
            if ({last_lap, best_lap} !== {to_time(m_last), to_time(m_best)}) begin
                miscompares++;
                $display("FAIL lap_regs @%0d: got last=%h best=%h want last=%h best=%h", a,
                         last_lap, best_lap, to_time(m_last), to_time(m_best));
            end
        end
        if (with_read) begin
            vectors++;
            if ({rd_hit, rd_data} !== {pre_hit, pre_data}) begin
                miscompares++;
                $display("FAIL read_during_write: got hit=%b data=%h want hit=%b data=%h",
                         rd_hit, rd_data, pre_hit, pre_data);
            end
        end
        laser_detector = 1'b1;
        repeat (4) @(negedge master_clk);
    endtask

    task automatic break_at(input int t_cs, input bit with_clear, input bit with_read);
        int target;
        target = zero + 1 + CLK_DIV * t_cs + int'($urandom_range(0, CLK_DIV - 1)) - 4;
        while (cyc < target) @(negedge master_clk);
        do_break(with_clear, with_read);
    endtask

    task automatic check_read(input int idx);
        int n;
        bit e_hit;
        logic [20:0] e_data;
        rd_en = 1'b1;
        rd_idx = 2'(idx);
        @(posedge master_clk);
        @(negedge master_clk);
        rd_en = 1'b0;
        n = m_laps.size();
        e_hit = (idx < n) && (idx < LAP_DEPTH);
        e_data = e_hit ? to_time(m_laps[n-1-idx]) : 21'd0;
        vectors++;
        if ({rd_hit, rd_data} !== {e_hit, e_data}) begin
            miscompares++;
            $display("FAIL read_idx%0d: got hit=%b data=%h want hit=%b data=%h",
                     idx, rd_hit, rd_data, e_hit, e_data);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge master_clk);
        @(negedge master_clk);
        clear = 1'b0;
        model_reset();
        vectors++;
        if ({running, lockout, cur_time, lap_strobe, best_valid, lap_count, overflow} !== 33'd0) begin
            miscompares++;
            $display("FAIL clear_state: got %h want 0",
                     {running, lockout, cur_time, lap_strobe, best_valid, lap_count, overflow});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge master_clk);
        vectors++;
        if ({running, lockout, cur_time, lap_strobe, last_lap, best_lap, best_valid,
             lap_count, overflow, rd_data, rd_hit} !== 98'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 0", {running, lockout, cur_time, lap_strobe,
                     last_lap, best_lap, best_valid, lap_count, overflow, rd_data, rd_hit});
        end
        rs = 1'b0;
        model_reset();
        repeat (2) @(negedge master_clk);
        do_break(1'b0, 1'b0);
        while (cyc < zero + CLK_DIV * 37) @(negedge master_clk);
        vectors++;
        if (cur_time !== to_time(37)) begin
            miscompares++;
            $display("FAIL pre_reset_time: got %h want %h", cur_time, to_time(37));
        end
        #2 rs = 1'b1;
        #1;
        vectors++;
        if ({running, lockout, cur_time, lap_strobe, last_lap, best_lap, best_valid,
             lap_count, overflow, rd_data, rd_hit} !== 98'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h want 0", {running, lockout, cur_time, lap_strobe,
                     last_lap, best_lap, best_valid, lap_count, overflow, rd_data, rd_hit});
        end
        @(negedge master_clk);
        rs = 1'b0;
        model_reset();
        repeat (2) @(negedge master_clk);
    endtask

    task automatic test_lockout_first_lap();
        do_break(1'b0, 1'b0);
        break_at(50, 1'b0, 1'b0);
        break_at(120, 1'b0, 1'b0);
    endtask

    task automatic test_best_and_read();
        do_clear();
        do_break(1'b0, 1'b0);
        break_at(300, 1'b0, 1'b0);
        break_at(105, 1'b0, 1'b0);
        break_at(210, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check_read(i);
    endtask

    task automatic test_history_wrap();
        do_clear();
        do_break(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) break_at(100 + int'($urandom_range(0, 60)), 1'b0, i == 5);
        for (int i = 0; i < 4; i++) check_read(i);
    endtask

    task automatic test_overflow();
        while (cyc < zero + CLK_DIV * (MAX_CS + 1) + 8) @(negedge master_clk);
        vectors++;
        if ({cur_time, overflow} !== {to_time(MAX_CS), 1'b1}) begin
            miscompares++;
            $display("FAIL saturate: got time=%h ovf=%b want time=%h ovf=1",
                     cur_time, overflow, to_time(MAX_CS));
        end
        do_break(1'b0, 1'b0);
    endtask

    task automatic test_clear_and_glitch();
        break_at(150, 1'b1, 1'b0);
        laser_detector = 1'b0;
        #2 laser_detector = 1'b1;
        repeat (10) @(negedge master_clk);
        vectors++;
        if ({running, lap_count} !== 9'd0) begin
            miscompares++;
            $display("FAIL glitch_ignored: got run=%b cnt=%0d want run=0 cnt=0", running, lap_count);
        end
        do_break(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_lockout_first_lap();
        test_best_and_read();
        test_history_wrap();
        test_overflow();
        test_clear_and_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
